// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: read-owner encoding and the muxed memory request.
package DmemArbPkg;

    localparam int unsigned DMEM_ADDR_MAX_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } dmem_owner_t;

    // addr is sized for the widest supported bank; the arbiter uses the low ADDR_W bits.
    typedef struct packed {
        logic [3:0]                 we;
        logic [DMEM_ADDR_MAX_W-1:0] addr;
        logic [31:0]                data;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Two-requester grant logic: DMA wins, optionally overridden after MAX_WAIT CPU denials.
// Optional starvation guard enabled by `define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arb_grant
`ifdef DMEM_ARB_STARVE_GUARD_EN
#(
    parameter int unsigned MAX_WAIT = 8
)
`endif
(
`ifdef DMEM_ARB_STARVE_GUARD_EN
    input  logic clk_i,
    input  logic rst_ni,
`endif
    input  logic cpu_req_i,
    input  logic dma_req_i,
    output logic cpu_gnt_o,
    output logic dma_gnt_o
);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] cpu_wait;
    logic              cpu_force;

    assign cpu_force = cpu_req_i && (cpu_wait == WAIT_W'(MAX_WAIT));
    assign cpu_gnt_o = cpu_req_i && (!dma_req_i || cpu_force);
    assign dma_gnt_o = dma_req_i && !cpu_force;

    // A forced grant also clears the counter, so saturation only holds while denied.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpu_wait <= '0;
        end else if (!cpu_req_i || cpu_gnt_o) begin
            cpu_wait <= '0;
        end else if (!cpu_force) begin
            cpu_wait <= cpu_wait + 1'b1;
        end
    end
`else
    assign cpu_gnt_o = cpu_req_i && !dma_req_i;
    assign dma_gnt_o = dma_req_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU data port and the DMNI DMA port.
// Optional CPU starvation guard enabled by `define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
    import DmemArbPkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned ADDR_W   = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cpu_req_i,
    input  logic [3:0]        cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic              cpu_gnt_o,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [31:0]       cpu_data_o,

    input  logic              dma_req_i,
    input  logic [3:0]        dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [31:0]       dma_data_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [31:0]       dma_data_o,

    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i,

    output logic [31:0]       conflict_cnt_o
);

    if (MAX_WAIT == 0 || ADDR_W == 0 || ADDR_W > DMEM_ADDR_MAX_W) begin : g_bad_params
        $error("dmem_arbiter: MAX_WAIT must be >= 1 and ADDR_W in 1..32");
    end

    dmem_owner_t rd_owner;
    dmem_owner_t rd_owner_nxt;
    dmem_req_t   mem_req;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    dmem_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .cpu_req_i (cpu_req_i),
        .dma_req_i (dma_req_i),
        .cpu_gnt_o (cpu_gnt_o),
        .dma_gnt_o (dma_gnt_o)
    );
`else
    dmem_arb_grant u_grant (
        .cpu_req_i (cpu_req_i),
        .dma_req_i (dma_req_i),
        .cpu_gnt_o (cpu_gnt_o),
        .dma_gnt_o (dma_gnt_o)
    );
`endif

    assign cpu_stall_o = cpu_req_i & ~cpu_gnt_o;

    always_comb begin
        mem_req = '0;
        if (dma_gnt_o) begin
            mem_req.we               = dma_we_i;
            mem_req.addr[ADDR_W-1:0] = dma_addr_i;
            mem_req.data             = dma_data_i;
        end else if (cpu_gnt_o) begin
            mem_req.we               = cpu_we_i;
            mem_req.addr[ADDR_W-1:0] = cpu_addr_i;
            mem_req.data             = cpu_data_i;
        end
    end

    assign mem_en_o   = cpu_gnt_o | dma_gnt_o;
    assign mem_we_o   = mem_req.we;
    assign mem_addr_o = mem_req.addr[ADDR_W-1:0];
    assign mem_data_o = mem_req.data;

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (dma_gnt_o && dma_we_i == 4'b0000) begin
            rd_owner_nxt = OWN_DMA;
        end else if (cpu_gnt_o && cpu_we_i == 4'b0000) begin
            rd_owner_nxt = OWN_CPU;
        end
    end

    // Owner is tracked independently of the current grant so a new grant cannot steal a pending return.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    assign cpu_rvalid_o = (rd_owner == OWN_CPU);
    assign dma_rvalid_o = (rd_owner == OWN_DMA);
    assign cpu_data_o   = cpu_rvalid_o ? mem_data_i : 32'h0;
    assign dma_data_o   = dma_rvalid_o ? mem_data_i : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_o <= '0;
        end else if (cpu_req_i && dma_req_i) begin
            conflict_cnt_o <= conflict_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; inputs change on the falling edge.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cpu_req_i;
    logic [3:0]  cpu_we_i;
    logic [23:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_gnt_o, cpu_stall_o, cpu_rvalid_o;
    logic [31:0] cpu_data_o;
    logic        dma_req_i;
    logic [3:0]  dma_we_i;
    logic [23:0] dma_addr_i;
    logic [31:0] dma_data_i;
    logic        dma_gnt_o, dma_rvalid_o;
    logic [31:0] dma_data_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [23:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i = 32'h0;
    logic [31:0] conflict_cnt_o;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.MAX_WAIT(8), .ADDR_W(24)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cpu_req_i      (cpu_req_i),
        .cpu_we_i       (cpu_we_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_gnt_o      (cpu_gnt_o),
        .cpu_stall_o    (cpu_stall_o),
        .cpu_rvalid_o   (cpu_rvalid_o),
        .cpu_data_o     (cpu_data_o),
        .dma_req_i      (dma_req_i),
        .dma_we_i       (dma_we_i),
        .dma_addr_i     (dma_addr_i),
        .dma_data_i     (dma_data_i),
        .dma_gnt_o      (dma_gnt_o),
        .dma_rvalid_o   (dma_rvalid_o),
        .dma_data_o     (dma_data_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rd_word(input logic [23:0] a);
        return (a == 24'h10) ? 32'hDEADBEEF : {8'hC0, a};
    endfunction

    // Memory macro model: read data appears one cycle after an enabled read.
    always @(posedge clk_i) begin
        if (mem_en_o && mem_we_o == 4'b0000) mem_data_i <= rd_word(mem_addr_o);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        cpu_req_i = 1'b0; cpu_we_i = 4'h0; cpu_addr_i = 24'h0; cpu_data_i = 32'h0;
        dma_req_i = 1'b0; dma_we_i = 4'h0; dma_addr_i = 24'h0; dma_data_i = 32'h0;
    endtask

    task automatic next_negedge();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        next_negedge();
        checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en_o); end
        checks++; if (mem_we_o !== 4'h0) begin errors++; $display("FAIL reset_mem_we got %h exp 0", mem_we_o); end
        checks++; if ({cpu_gnt_o, dma_gnt_o, cpu_stall_o} !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", {cpu_gnt_o, dma_gnt_o, cpu_stall_o}); end
        checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {cpu_rvalid_o, dma_rvalid_o}); end
        checks++; if ({cpu_data_o, dma_data_o} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {cpu_data_o, dma_data_o}); end
        checks++; if (conflict_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_conflict got %0d exp 0", conflict_cnt_o); end
    endtask

    task automatic test_cpu_read();
        cpu_req_i = 1'b1; cpu_we_i = 4'h0; cpu_addr_i = 24'h10;
        #4;
        checks++; if ({cpu_gnt_o, cpu_stall_o, mem_en_o} !== 3'b101) begin errors++; $display("FAIL cpu_read_gnt got %b exp 101", {cpu_gnt_o, cpu_stall_o, mem_en_o}); end
        checks++; if (mem_addr_o !== 24'h10 || mem_we_o !== 4'h0) begin errors++; $display("FAIL cpu_read_mem got %h/%h exp 000010/0", mem_addr_o, mem_we_o); end
        next_negedge();
        cpu_req_i = 1'b0;
        checks++; if (cpu_rvalid_o !== 1'b1 || dma_rvalid_o !== 1'b0) begin errors++; $display("FAIL cpu_read_rvalid got %b%b exp 10", cpu_rvalid_o, dma_rvalid_o); end
        checks++; if (cpu_data_o !== 32'hDEADBEEF || dma_data_o !== 32'h0) begin errors++; $display("FAIL cpu_read_data got %h/%h exp deadbeef/0", cpu_data_o, dma_data_o); end
        next_negedge();
        checks++; if (cpu_rvalid_o !== 1'b0 || cpu_data_o !== 32'h0) begin errors++; $display("FAIL cpu_read_done got %b/%h exp 0/0", cpu_rvalid_o, cpu_data_o); end
    endtask

    task automatic test_conflict();
        cpu_req_i = 1'b1; cpu_we_i = 4'h0; cpu_addr_i = 24'h20;
        dma_req_i = 1'b1; dma_we_i = 4'hF; dma_addr_i = 24'h30; dma_data_i = 32'h12345678;
        #4;
        checks++; if ({dma_gnt_o, cpu_gnt_o, cpu_stall_o} !== 3'b101) begin errors++; $display("FAIL conflict_gnt got %b exp 101", {dma_gnt_o, cpu_gnt_o, cpu_stall_o}); end
        checks++; if (mem_we_o !== 4'hF || mem_addr_o !== 24'h30 || mem_data_o !== 32'h12345678) begin errors++; $display("FAIL conflict_mem got %h/%h/%h exp f/000030/12345678", mem_we_o, mem_addr_o, mem_data_o); end
        next_negedge();
        dma_req_i = 1'b0; dma_we_i = 4'h0;
        #1;
        checks++; if ({cpu_gnt_o, cpu_stall_o} !== 2'b10) begin errors++; $display("FAIL conflict_cpu_next got %b exp 10", {cpu_gnt_o, cpu_stall_o}); end
        checks++; if (conflict_cnt_o !== 32'd1) begin errors++; $display("FAIL conflict_cnt got %0d exp 1", conflict_cnt_o); end
        checks++; if (dma_rvalid_o !== 1'b0) begin errors++; $display("FAIL conflict_write_rvalid got %b exp 0", dma_rvalid_o); end
        next_negedge();
        cpu_req_i = 1'b0;
        checks++; if (cpu_rvalid_o !== 1'b1 || cpu_data_o !== 32'hC0000020) begin errors++; $display("FAIL conflict_cpu_data got %b/%h exp 1/c0000020", cpu_rvalid_o, cpu_data_o); end
        checks++; if (conflict_cnt_o !== 32'd1) begin errors++; $display("FAIL conflict_cnt_hold got %0d exp 1", conflict_cnt_o); end
    endtask

    task automatic test_partial_write();
        cpu_req_i = 1'b1; cpu_we_i = 4'b0101; cpu_addr_i = 24'h44; cpu_data_i = 32'hA5A55A5A;
        #4;
        checks++; if (mem_we_o !== 4'b0101 || mem_data_o !== 32'hA5A55A5A || mem_addr_o !== 24'h44) begin errors++; $display("FAIL partial_write_mem got %h/%h/%h exp 5/a5a55a5a/000044", mem_we_o, mem_data_o, mem_addr_o); end
        next_negedge();
        idle_inputs();
        checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00) begin errors++; $display("FAIL partial_write_rvalid got %b exp 00", {cpu_rvalid_o, dma_rvalid_o}); end
        next_negedge();
    endtask

    task automatic test_starve();
        int n_cycles;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        n_cycles = 9;
`else
        n_cycles = 12;
`endif
        dma_req_i = 1'b1; dma_we_i = 4'h0; dma_addr_i = 24'h40;
        cpu_req_i = 1'b1; cpu_we_i = 4'h0; cpu_addr_i = 24'h50;
        for (int k = 1; k <= n_cycles; k++) begin
            logic exp_cpu;
            #4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
            exp_cpu = (k == 9);
`else
            exp_cpu = 1'b0;
`endif
            checks++;
            if (cpu_gnt_o !== exp_cpu || dma_gnt_o !== !exp_cpu) begin
                errors++;
                $display("FAIL starve_cycle%0d got cpu=%b dma=%b exp cpu=%b dma=%b", k, cpu_gnt_o, dma_gnt_o, exp_cpu, !exp_cpu);
            end
            next_negedge();
        end
        idle_inputs();
        checks++; if (conflict_cnt_o !== 32'd1 + 32'(n_cycles)) begin errors++; $display("FAIL starve_conflict_cnt got %0d exp %0d", conflict_cnt_o, 1 + n_cycles); end
        next_negedge();
    endtask

    task automatic test_alternating();
        logic [23:0] addrs [4];
        addrs[0] = 24'h100; addrs[1] = 24'h200; addrs[2] = 24'h300; addrs[3] = 24'h400;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                logic prev_cpu;
                logic [31:0] exp_d;
                prev_cpu = ((i - 1) % 2 == 0);
                exp_d = rd_word(addrs[i-1]);
                checks++;
                if (cpu_rvalid_o !== prev_cpu || dma_rvalid_o !== !prev_cpu) begin
                    errors++;
                    $display("FAIL alt_rvalid%0d got cpu=%b dma=%b exp cpu=%b", i, cpu_rvalid_o, dma_rvalid_o, prev_cpu);
                end
                checks++;
                if ((prev_cpu ? cpu_data_o : dma_data_o) !== exp_d || (prev_cpu ? dma_data_o : cpu_data_o) !== 32'h0) begin
                    errors++;
                    $display("FAIL alt_data%0d got cpu=%h dma=%h exp %h", i, cpu_data_o, dma_data_o, exp_d);
                end
            end
            idle_inputs();
            if (i < 4) begin
                if (i % 2 == 0) begin cpu_req_i = 1'b1; cpu_addr_i = addrs[i]; end
                else            begin dma_req_i = 1'b1; dma_addr_i = addrs[i]; end
            end
            next_negedge();
        end
    endtask

    task automatic test_reset_mid_read();
        cpu_req_i = 1'b1; cpu_we_i = 4'h0; cpu_addr_i = 24'h10;
        dma_req_i = 1'b1; dma_we_i = 4'h0; dma_addr_i = 24'h80;
        @(posedge clk_i);
        #1;
        checks++; if (dma_rvalid_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pending got %b exp 1", dma_rvalid_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00 || dma_data_o !== 32'h0) begin errors++; $display("FAIL rst_mid_drop got %b/%h exp 00/0", {cpu_rvalid_o, dma_rvalid_o}, dma_data_o); end
        checks++; if (conflict_cnt_o !== 32'h0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", conflict_cnt_o); end
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_negedge();
            checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_mid_after%0d got %b exp 00", k, {cpu_rvalid_o, dma_rvalid_o}); end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_conflict();
        test_partial_write();
        test_starve();
        test_alternating();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
